// File: rtl/ins_dec_core.sv
// Registered RV32I instruction-field decoder: one-cycle latency, fields outside the format are zeroed.
// Optional INS_DEC_ILLEGAL_EN adds a registered 'illegal' flag for unknown opcodes or bad [1:0].
module ins_dec_core (
    input  logic [31:0] pass_bits,
    input  logic        clk,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  func3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  func7,
    output logic [19:0] imm12,
    output logic [11:0] imm20,
    input  logic        rst_n
`ifdef INS_DEC_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_e;

    fmt_e        w_fmt;
    logic [4:0]  w_rd;
    logic [2:0]  w_func3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_func7;
    logic [19:0] w_imm12;
    logic [11:0] w_imm20;

    logic [6:0]  r_opcode;
    logic [4:0]  r_rd;
    logic [2:0]  r_func3;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [6:0]  r_func7;
    logic [19:0] r_imm12;
    logic [11:0] r_imm20;

    always_comb begin
        w_fmt = FMT_X;
        case (pass_bits[6:0])
            7'b0110011:                          w_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b0001111, 7'b1110011:              w_fmt = FMT_I;
            7'b0100011:                          w_fmt = FMT_S;
            7'b1100011:                          w_fmt = FMT_B;
            7'b0110111, 7'b0010111:              w_fmt = FMT_U;
            7'b1101111:                          w_fmt = FMT_J;
            default:                             w_fmt = FMT_X;
        endcase
    end

    always_comb begin
        w_rd    = '0;
        w_func3 = '0;
        w_rs1   = '0;
        w_rs2   = '0;
        w_func7 = '0;
        w_imm12 = '0;
        w_imm20 = '0;
        case (w_fmt)
            FMT_R: begin
                w_rd    = pass_bits[11:7];
                w_func3 = pass_bits[14:12];
                w_rs1   = pass_bits[19:15];
                w_rs2   = pass_bits[24:20];
                w_func7 = pass_bits[31:25];
            end
            // Shift-immediates keep their funct7-like bits inside imm20, not func7.
            FMT_I: begin
                w_rd    = pass_bits[11:7];
                w_func3 = pass_bits[14:12];
                w_rs1   = pass_bits[19:15];
                w_imm20 = pass_bits[31:20];
            end
            FMT_S: begin
                w_func3 = pass_bits[14:12];
                w_rs1   = pass_bits[19:15];
                w_rs2   = pass_bits[24:20];
                w_imm20 = {pass_bits[31:25], pass_bits[11:7]};
            end
            FMT_B: begin
                w_func3 = pass_bits[14:12];
                w_rs1   = pass_bits[19:15];
                w_rs2   = pass_bits[24:20];
                w_imm20 = {pass_bits[31], pass_bits[7], pass_bits[30:25], pass_bits[11:8]};
            end
            FMT_U: begin
                w_rd    = pass_bits[11:7];
                w_imm12 = pass_bits[31:12];
            end
            FMT_J: begin
                w_rd    = pass_bits[11:7];
                w_imm12 = {pass_bits[31], pass_bits[19:12], pass_bits[20], pass_bits[30:21]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= '0;
            r_rd     <= '0;
            r_func3  <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_func7  <= '0;
            r_imm12  <= '0;
            r_imm20  <= '0;
        end else begin
            r_opcode <= pass_bits[6:0];
            r_rd     <= w_rd;
            r_func3  <= w_func3;
            r_rs1    <= w_rs1;
            r_rs2    <= w_rs2;
            r_func7  <= w_func7;
            r_imm12  <= w_imm12;
            r_imm20  <= w_imm20;
        end
    end

    assign opcode = r_opcode;
    assign rd     = r_rd;
    assign func3  = r_func3;
    assign rs1    = r_rs1;
    assign rs2    = r_rs2;
    assign func7  = r_func7;
    assign imm12  = r_imm12;
    assign imm20  = r_imm20;

`ifdef INS_DEC_ILLEGAL_EN
    logic w_illegal;
    logic r_illegal;

    assign w_illegal = (w_fmt == FMT_X) || (pass_bits[1:0] != 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_illegal;
        end
    end

    assign illegal = r_illegal;
`endif

endmodule

// File: tb/tb_ins_dec_core.sv
// Scoreboard bench for ins_dec_core: expectations queued at drive time, popped one edge later.
module tb_ins_dec_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] pass_bits;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;
    logic [19:0] imm12;
    logic [11:0] imm20;
`ifdef INS_DEC_ILLEGAL_EN
    logic        illegal;
`endif

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [19:0] i12;
        logic [11:0] i20;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ins_dec_core dut (
        .pass_bits (pass_bits),
        .clk       (clk),
        .opcode    (opcode),
        .rd        (rd),
        .func3     (func3),
        .rs1       (rs1),
        .rs2       (rs2),
        .func7     (func7),
        .imm12     (imm12),
        .imm20     (imm20),
        .rst_n     (rst_n)
`ifdef INS_DEC_ILLEGAL_EN
        ,
        .illegal   (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".opcode"}, 32'(opcode), 32'(e.op));
        chk({tag, ".rd"},     32'(rd),     32'(e.rd));
        chk({tag, ".func3"},  32'(func3),  32'(e.f3));
        chk({tag, ".rs1"},    32'(rs1),    32'(e.rs1));
        chk({tag, ".rs2"},    32'(rs2),    32'(e.rs2));
        chk({tag, ".func7"},  32'(func7),  32'(e.f7));
        chk({tag, ".imm12"},  32'(imm12),  32'(e.i12));
        chk({tag, ".imm20"},  32'(imm20),  32'(e.i20));
`ifdef INS_DEC_ILLEGAL_EN
        chk({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
`endif
    endtask

    function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rdv, input logic [2:0] f3,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] f7,
                                input logic [19:0] i12, input logic [11:0] i20, input logic ill);
        exp_t e;
        e.op = op; e.rd = rdv; e.f3 = f3; e.rs1 = r1; e.rs2 = r2;
        e.f7 = f7; e.i12 = i12; e.i20 = i20; e.ill = ill;
        return e;
    endfunction

    // Reference decode written from the field-validity table.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic fr, fi, fs, fb, fu, fj;
        logic [6:0] o;
        o  = w[6:0];
        fr = (o == 7'h33);
        fi = (o == 7'h13) || (o == 7'h03) || (o == 7'h67) || (o == 7'h0F) || (o == 7'h73);
        fs = (o == 7'h23);
        fb = (o == 7'h63);
        fu = (o == 7'h37) || (o == 7'h17);
        fj = (o == 7'h6F);
        e.op  = o;
        e.rd  = (fr || fi || fu || fj) ? w[11:7] : 5'd0;
        e.f3  = (fr || fi || fs || fb) ? w[14:12] : 3'd0;
        e.rs1 = (fr || fi || fs || fb) ? w[19:15] : 5'd0;
        e.rs2 = (fr || fs || fb) ? w[24:20] : 5'd0;
        e.f7  = fr ? w[31:25] : 7'd0;
        e.i20 = fi ? w[31:20] :
                fs ? {w[31:25], w[11:7]} :
                fb ? {w[31], w[7], w[30:25], w[11:8]} : 12'd0;
        e.i12 = fu ? w[31:12] :
                fj ? {w[31], w[19:12], w[20], w[30:21]} : 20'd0;
        e.ill = !(fr || fi || fs || fb || fu || fj) || (w[1:0] != 2'b11);
        return e;
    endfunction

    task automatic step(input string tag, input logic [31:0] w, input exp_t e);
        exp_t got_e;
        pass_bits = w;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got_e = sb_q.pop_front();
            chk_all(tag, got_e);
        end
    endtask

    localparam exp_t ZERO = '0;

    initial begin
        logic [6:0] ops [12];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};

        rst_n     = 1'b0;
        pass_bits = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("reset_release", ZERO);
        @(posedge clk);
        #1;

        step("R_sub",  32'h4020_8133, mk(7'h33, 5'd2, 3'd0, 5'd1, 5'd2, 7'h20, 20'h0, 12'h000, 1'b0));
        step("I_addi", 32'h0051_0093, mk(7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'h00, 20'h0, 12'h005, 1'b0));
        step("S_sw",   32'h0020_A423, mk(7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 20'h0, 12'h008, 1'b0));
        step("B_beq",  32'hFE20_8EE3, mk(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 20'h0, 12'hFFE, 1'b0));
        step("U_lui",  32'h1234_52B7, mk(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 20'h12345, 12'h000, 1'b0));
        step("J_jal",  32'h0080_00EF, mk(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 20'h00004, 12'h000, 1'b0));
        step("X_unk",  32'h0000_007F, mk(7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 20'h0, 12'h000, 1'b1));
        step("I_slli", 32'h4030_9093, mk(7'h13, 5'd1, 3'd1, 5'd1, 5'd0, 7'h00, 20'h0, 12'h403, 1'b0));
        step("R_bad10", 32'h4020_8130, mk(7'h30, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 20'h0, 12'h000, 1'b1));

        for (int i = 0; i < 60; i++) begin
            w = $urandom();
            w[6:0] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) w[1:0] = 2'($urandom_range(0, 2));
            step("rand", w, model(w));
        end

        // Asynchronous reset in the middle of a cycle with non-zero outputs held.
        step("pre_rst", 32'h4020_8133, model(32'h4020_8133));
        pass_bits = 32'hFFFF_FFFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", ZERO);
        @(posedge clk);
        #1;
        chk_all("rst_hold", ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("rst_rel_noedge", ZERO);
        step("post_rst", 32'hFFFF_FFFF, mk(7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 20'h0, 12'h000, 1'b1));

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
